// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder: turns operation requests into 32-bit words,
// expands the LI pseudo-op into one or two words, and buffers them in a small FIFO.
module riscv_instr_encoder #(
    parameter int DEPTH     = 2,
    parameter int CHECK_IMM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_op_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_err_o,
    output logic        busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, EMIT2} state_t;
    typedef enum logic [3:0] {
        F_LUI, F_AUIPC, F_JAL, F_JALR, F_B, F_I, F_SH, F_R, F_LI, F_ECALL, F_EBREAK
    } fmt_t;

    state_t        state, state_nxt;
    fmt_t          fmt;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   imm;
    logic [4:0]    rd, rs1, rs2;
    logic          i_bad, sh_bad, b_bad, j_bad, u_bad;
    logic [31:0]   raw;
    logic          bad;
    logic          out_err;
    logic [31:0]   out_word;
    logic [19:0]   li_hi;
    logic [11:0]   li_lo;
    logic [31:0]   li_first;
    logic          li_two;
    logic [31:0]   second_q;

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, accept, push, pop;
    logic [32:0]   push_data;

    assign imm = req_imm_i;
    assign rd  = req_rd_i;
    assign rs1 = req_rs1_i;
    assign rs2 = req_rs2_i;

    always_comb begin
        fmt = F_R;
        f3  = '0;
        f7  = '0;
        case (req_op_i)
            5'd0:  fmt = F_LUI;
            5'd1:  fmt = F_AUIPC;
            5'd2:  fmt = F_JAL;
            5'd3:  fmt = F_JALR;
            5'd4:  begin fmt = F_B;  f3 = 3'd0; end
            5'd5:  begin fmt = F_B;  f3 = 3'd1; end
            5'd6:  begin fmt = F_B;  f3 = 3'd4; end
            5'd7:  begin fmt = F_B;  f3 = 3'd5; end
            5'd8:  begin fmt = F_B;  f3 = 3'd6; end
            5'd9:  begin fmt = F_B;  f3 = 3'd7; end
            5'd10: begin fmt = F_I;  f3 = 3'd0; end
            5'd11: begin fmt = F_I;  f3 = 3'd2; end
            5'd12: begin fmt = F_I;  f3 = 3'd3; end
            5'd13: begin fmt = F_I;  f3 = 3'd4; end
            5'd14: begin fmt = F_I;  f3 = 3'd6; end
            5'd15: begin fmt = F_I;  f3 = 3'd7; end
            5'd16: begin fmt = F_SH; f3 = 3'd1; end
            5'd17: begin fmt = F_SH; f3 = 3'd5; end
            5'd18: begin fmt = F_SH; f3 = 3'd5; f7 = 7'h20; end
            5'd19: f3 = 3'd0;
            5'd20: begin f3 = 3'd0; f7 = 7'h20; end
            5'd21: f3 = 3'd1;
            5'd22: f3 = 3'd2;
            5'd23: f3 = 3'd3;
            5'd24: f3 = 3'd4;
            5'd25: f3 = 3'd5;
            5'd26: begin f3 = 3'd5; f7 = 7'h20; end
            5'd27: f3 = 3'd6;
            5'd28: f3 = 3'd7;
            5'd29: fmt = F_LI;
            5'd30: fmt = F_ECALL;
            default: fmt = F_EBREAK;
        endcase
    end

    // Signed range checks: the bits above the field must be pure sign extension.
    assign i_bad  = !((&imm[31:11]) || !(|imm[31:11]));
    assign sh_bad = |imm[31:5];
    assign b_bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
    assign j_bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
    assign u_bad  = |imm[31:20];

    // (imm + 0x800) >> 12 reduces to adding imm[11] into the upper bits.
    assign li_hi    = imm[31:12] + {19'b0, imm[11]};
    assign li_lo    = imm[11:0];
    assign li_two   = (li_hi != '0) && (li_lo != '0);
    assign li_first = (li_hi == '0) ? {li_lo, 5'd0, 3'b000, rd, 7'b0010011}
                                    : {li_hi, rd, 7'b0110111};

    always_comb begin
        raw = '0;
        bad = 1'b0;
        case (fmt)
            F_LUI:    begin raw = {imm[19:0], rd, 7'b0110111}; bad = u_bad; end
            F_AUIPC:  begin raw = {imm[19:0], rd, 7'b0010111}; bad = u_bad; end
            F_JAL:    begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                bad = j_bad;
            end
            F_JALR:   begin raw = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; bad = i_bad; end
            F_B:      begin
                raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
                bad = b_bad;
            end
            F_I:      begin raw = {imm[11:0], rs1, f3, rd, 7'b0010011}; bad = i_bad; end
            F_SH:     begin raw = {f7, imm[4:0], rs1, f3, rd, 7'b0010011}; bad = sh_bad; end
            F_R:      raw = {f7, rs2, rs1, f3, rd, 7'b0110011};
            F_LI:     raw = li_first;
            F_ECALL:  raw = 32'h0000_0073;
            F_EBREAK: raw = 32'h0010_0073;
            default:  raw = '0;
        endcase
    end

    assign out_err  = (CHECK_IMM != 0) && bad;
    assign out_word = out_err ? '0 : raw;

    assign full          = (count == FULL_CNT);
    assign req_ready_o   = (state == IDLE) && !full;
    assign accept        = req_valid_i && req_ready_o;
    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign {instr_err_o, instr_o} = instr_valid_o ? mem[rd_ptr] : '0;
    assign busy_o        = (state != IDLE) || instr_valid_o;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = {out_err, out_word};
        case (state)
            IDLE: begin
                if (accept) begin
                    push = 1'b1;
                    if (fmt == F_LI && li_two) state_nxt = EMIT2;
                end
            end
            EMIT2: begin
                push_data = {1'b0, second_q};
                if (!full) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            second_q <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept)
                second_q <= {li_lo, rd, 3'b000, rd, 7'b0010011};
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule
